// File: rtl/dmem_store_buffer_if.sv
// M-stage data-memory bus between the pipeline (master) and dmem_store_buffer (slave).
interface dmem_store_buffer_if #(
  parameter int SB_DEPTH = 4
);
  logic                      MemWriteM;
  logic                      MemReadM;
  logic [31:0]               ALUOutM;
  logic [31:0]               WriteDataM;
  logic [31:0]               DmmRD;
  logic                      StallM;
  logic [$clog2(SB_DEPTH):0] SbCount;

  modport master (
    output MemWriteM, MemReadM, ALUOutM, WriteDataM,
    input  DmmRD, StallM, SbCount
  );

  modport slave (
    input  MemWriteM, MemReadM, ALUOutM, WriteDataM,
    output DmmRD, StallM, SbCount
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// M-stage data memory: posted-store FIFO draining one entry per cycle into a word RAM.
// Define DMEM_BYPASS_EN to forward loads from buffered stores; otherwise matching loads stall.
module dmem_store_buffer #(
  parameter int RAM_AW   = 6,
  parameter int SB_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  dmem_store_buffer_if.slave mem
);
  localparam int PW = $clog2(SB_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [31:0]       ram    [2**RAM_AW];
  logic [RAM_AW-1:0] sbIdx  [SB_DEPTH];
  logic [31:0]       sbData [SB_DEPTH];

  ptr_t              head;
  ptr_t              tail;
  cnt_t              count;
  ptr_t              pos;
  logic [RAM_AW-1:0] idx;
  logic              full;
  logic              enq;
  logic              drainEn;
  logic              hit;
  logic              loadStall;
  logic              unusedAddrBits;
`ifdef DMEM_BYPASS_EN
  logic [31:0]       fwdData;
`endif

  assign idx            = mem.ALUOutM[RAM_AW+1:2];
  assign unusedAddrBits = ^{mem.ALUOutM[31:RAM_AW+2], mem.ALUOutM[1:0]};
  assign full           = (count == cnt_t'(SB_DEPTH));
  assign enq            = !reset && mem.MemWriteM && !full;
  assign drainEn        = !reset && (count != '0);

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit = 1'b0;
    pos = head;
`ifdef DMEM_BYPASS_EN
    fwdData = '0;
`endif
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      pos = head + ptr_t'(k);
      if ((cnt_t'(k) < count) && (sbIdx[pos] == idx)) begin
        hit = 1'b1;
`ifdef DMEM_BYPASS_EN
        fwdData = sbData[pos];
`endif
      end
    end
  end

  always_comb begin
`ifdef DMEM_BYPASS_EN
    loadStall = 1'b0;
    mem.DmmRD = (!reset && mem.MemReadM && hit) ? fwdData : ram[idx];
`else
    loadStall = !reset && mem.MemReadM && hit;
    mem.DmmRD = ram[idx];
`endif
    mem.StallM = (!reset && mem.MemWriteM && full) || loadStall;
  end

  assign mem.SbCount = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        sbIdx[tail]  <= idx;
        sbData[tail] <= mem.WriteDataM;
        tail         <= tail + 1'b1;
      end
      if (drainEn) head <= head + 1'b1;
      case ({enq, drainEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Drain write lands at the edge, so same-cycle reads still see the old word.
  always_ff @(posedge clk) begin
    if (drainEn) ram[sbIdx[head]] <= sbData[head];
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: queue/array reference model checked every cycle plus directed literals.
module tb_dmem_store_buffer;
  localparam int RAM_AW   = 6;
  localparam int SB_DEPTH = 4;
`ifdef DMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_store_buffer_if #(.SB_DEPTH(SB_DEPTH)) bus ();

  dmem_store_buffer #(.RAM_AW(RAM_AW), .SB_DEPTH(SB_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (bus)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } st_t;

  st_t         pend [$];
  logic [31:0] ramM [int unsigned];
  bit          holdDrain = 1'b0;
  bit          started   = 1'b0;
  int          nChecks   = 0;
  int          nFail     = 0;

  function automatic int unsigned widx(logic [31:0] a);
    return (int'(a) >>> 2) & ((1 << RAM_AW) - 1);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a queue of pending stores in program order and a sparse RAM image.
  always @(posedge clk) begin : model
    int sz;
    if (reset) begin
      pend.delete();
      started = 1'b1;
    end else begin
      sz = pend.size();
      if (sz > 0 && !holdDrain) begin
        ramM[pend[0].idx] = pend[0].data;
        void'(pend.pop_front());
      end
      if (bus.MemWriteM && sz < SB_DEPTH)
        pend.push_back('{widx(bus.ALUOutM), bus.WriteDataM});
    end
  end

  always @(negedge clk) begin : cmp
    int unsigned ix;
    bit          hitM;
    logic [31:0] hv;
    bit          expStall;
    if (started) begin
      ix   = widx(bus.ALUOutM);
      hitM = 1'b0;
      hv   = '0;
      foreach (pend[i]) if (pend[i].idx == ix) begin
        hitM = 1'b1;
        hv   = pend[i].data;
      end
      expStall = !reset && ((bus.MemWriteM && pend.size() == SB_DEPTH) ||
                            (!BYP && bus.MemReadM && hitM));
      check("model StallM", {31'b0, bus.StallM}, {31'b0, expStall});
      check("model SbCount", 32'(bus.SbCount), pend.size());
      if (!reset && bus.MemReadM && hitM) begin
        if (BYP) check("model DmmRD fwd", bus.DmmRD, hv);
      end else if (ramM.exists(ix)) begin
        check("model DmmRD ram", bus.DmmRD, ramM[ix]);
      end
    end
  end

  task automatic put(bit w, bit r, logic [31:0] a, logic [31:0] d);
    bus.MemWriteM  = w;
    bus.MemReadM   = r;
    bus.ALUOutM    = a;
    bus.WriteDataM = d;
    #2;
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(int n);
    put(1'b0, 1'b0, 32'h0, 32'h0);
    tick(n);
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    put(1'b1, 1'b0, a, d);
    tick();
  endtask

  task automatic loadCheck(string nm, logic [31:0] a, logic [31:0] exp);
    put(1'b0, 1'b1, a, 32'h0);
    check(nm, bus.DmmRD, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    put(1'b0, 1'b0, 32'h0, 32'h0);
    tick(2);
    reset = 1'b0;

    put(1'b0, 1'b0, 32'h0, 32'h0);
    check("reset SbCount", 32'(bus.SbCount), 32'd0);
    check("reset StallM", {31'b0, bus.StallM}, 32'd0);
    tick();

    store(32'h14, 32'hDEADBEEF);
    idle(1);
    loadCheck("preload RAM[5]", 32'h14, 32'hDEADBEEF);

    // store then immediate load of the same word
    store(32'h20, 32'h11111111);
    put(1'b0, 1'b1, 32'h20, 32'h0);
    if (BYP) check("st-ld fwd data", bus.DmmRD, 32'h11111111);
    check("st-ld stall", {31'b0, bus.StallM}, {31'b0, !BYP});
    tick();
    put(1'b0, 1'b1, 32'h20, 32'h0);
    check("st-ld stall end", {31'b0, bus.StallM}, 32'd0);
    check("st-ld data", bus.DmmRD, 32'h11111111);
    tick();

    // youngest match wins, free-running drain
    store(32'h40, 32'hA);
    store(32'h40, 32'hB);
    put(1'b0, 1'b1, 32'h40, 32'h0);
    if (BYP) check("youngest fwd", bus.DmmRD, 32'hB);
    tick();
    idle(2);
    loadCheck("RAM[16] after drain", 32'h40, 32'hB);

    // youngest match wins with two live entries
    holdDrain = 1'b1;
    force dut.drainEn = 1'b0;
    store(32'h44, 32'hA0);
    store(32'h44, 32'hB0);
    put(1'b0, 1'b1, 32'h44, 32'h0);
    if (BYP) check("youngest of two", bus.DmmRD, 32'hB0);
    check("two-match stall", {31'b0, bus.StallM}, {31'b0, !BYP});
    tick();
    holdDrain = 1'b0;
    release dut.drainEn;
    idle(3);
    loadCheck("RAM[17] after drain", 32'h44, 32'hB0);

    // load on the cycle its store drains
    store(32'h8, 32'h55);
    put(1'b0, 1'b1, 32'h8, 32'h0);
    if (BYP) check("drain-cycle fwd", bus.DmmRD, 32'h55);
    tick();
    loadCheck("drain-cycle after", 32'h8, 32'h55);

    // full buffer
    holdDrain = 1'b1;
    force dut.drainEn = 1'b0;
    store(32'h0C, 32'hF1);
    store(32'h10, 32'hF2);
    store(32'h14, 32'hF3);
    store(32'h18, 32'hF4);
    put(1'b0, 1'b0, 32'h0, 32'h0);
    check("full SbCount", 32'(bus.SbCount), 32'd4);
    holdDrain = 1'b0;
    release dut.drainEn;
    put(1'b1, 1'b0, 32'h0C, 32'hF5);
    check("full stall", {31'b0, bus.StallM}, 32'd1);
    tick();
    holdDrain = 1'b1;
    force dut.drainEn = 1'b0;
    put(1'b1, 1'b0, 32'h0C, 32'hF5);
    check("full accept no stall", {31'b0, bus.StallM}, 32'd0);
    check("full count after drain", 32'(bus.SbCount), 32'd3);
    tick();
    put(1'b0, 1'b0, 32'h0, 32'h0);
    check("full refilled", 32'(bus.SbCount), 32'd4);
    holdDrain = 1'b0;
    release dut.drainEn;
    idle(5);
    loadCheck("full RAM[3]", 32'h0C, 32'hF5);
    loadCheck("full RAM[4]", 32'h10, 32'hF2);
    loadCheck("full RAM[5]", 32'h14, 32'hF3);
    loadCheck("full RAM[6]", 32'h18, 32'hF4);

    // reset discards pending stores
    store(32'h0, 32'hC0);
    store(32'h4, 32'hC1);
    store(32'h8, 32'hC2);
    idle(2);
    holdDrain = 1'b1;
    force dut.drainEn = 1'b0;
    store(32'h100, 32'h1);
    store(32'h104, 32'h2);
    store(32'h108, 32'h3);
    put(1'b0, 1'b0, 32'h0, 32'h0);
    check("pending before reset", 32'(bus.SbCount), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    holdDrain = 1'b0;
    release dut.drainEn;
    put(1'b0, 1'b0, 32'h0, 32'h0);
    check("reset clears count", 32'(bus.SbCount), 32'd0);
    tick(3);
    loadCheck("RAM[0] kept", 32'h0, 32'hC0);
    loadCheck("RAM[1] kept", 32'h4, 32'hC1);
    loadCheck("RAM[2] kept", 32'h8, 32'hC2);

    // address aliasing
    store(32'h4 + 32'(4 * (1 << RAM_AW)), 32'hA1A5);
    idle(2);
    loadCheck("alias RAM[1]", 32'h4, 32'hA1A5);

    idle(1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
